ftran_sweep_ctrl: RTL and testbench
===================================

FTRAN_SWEEP_CTRL -- requirements
Module: ftran_sweep_ctrl

Interface
REQ-001 Parameter GOLDEN, 16 bits, default 16'hFC51; expected gate output per vector index {A,B,C,D}, bit n = f(n).
REQ-002 Parameter SETTLE_CYC, integer, default 2, legal 1..15; number of settle cycles between drive and sample.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a 16-vector sweep.
REQ-006 stop  input  1  abort request; ends a sweep in progress.
REQ-007 dut_out  input  1  output of the complex gate under control.
REQ-008 A, B, C, D  output  1 each  true-rail vector drive, registered.
REQ-009 notA, notB, notC, notD  output  1 each  complement-rail drive, registered, always the inverse of the matching true rail.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 err_cnt  output  5  mismatch count for the current or last sweep, 0..16.
REQ-014 first_fail  output  4  index of the first mismatching vector; 0 when there are no mismatches.
REQ-015 fail_map  output  16  bit n set when vector n mismatched.

Function
REQ-016 FSM states: IDLE, DRIVE, SETTLE, SAMPLE, FIN.
REQ-017 IDLE with start=1 and stop=0: clear err_cnt, fail_map, first_fail and pass, set idx=0, and go to DRIVE.
REQ-018 DRIVE lasts 1 cycle: {A,B,C,D}<=idx and not-rails<=~idx in the same edge, then go to SETTLE.
REQ-019 SETTLE lasts exactly SETTLE_CYC cycles, counted by a 4-bit down-counter, then go to SAMPLE.
REQ-020 SAMPLE lasts 1 cycle: compare dut_out with GOLDEN[idx]; on mismatch set fail_map[idx] and increment err_cnt; if this is the first mismatch, set first_fail=idx.
REQ-021 SAMPLE with idx=15 goes to FIN; otherwise idx increments and the FSM goes to DRIVE.
REQ-022 Each vector takes SETTLE_CYC+2 cycles; a full sweep takes 16*(SETTLE_CYC+2) cycles, which is 64 at the default.
REQ-023 FIN lasts 1 cycle: done=1, pass=(err_cnt==0), then go to IDLE.
REQ-024 busy=1 in DRIVE, SETTLE, SAMPLE and FIN; busy=0 in IDLE.
REQ-025 start while busy is ignored.
REQ-026 start and stop asserted in the same cycle while in IDLE: stop wins and no sweep starts.
REQ-027 stop in any busy state: go to IDLE next edge; done is not pulsed; pass=0; err_cnt, fail_map and first_fail hold their partial values; rails return to vector 0.
REQ-028 The rails are never both 0 or both 1 on any cycle, including reset entry and exit.
REQ-029 Results hold stable in IDLE until the next accepted start.

Reset
REQ-030 While rst_n=0: state=IDLE, idx=0, A=B=C=D=0, notA=notB=notC=notD=1, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_map=0.
REQ-031 rst_n asserted mid-sweep aborts the sweep immediately with the REQ-030 values; the first edge after release is in IDLE.

Structure
REQ-032 A shared package ftran_pkg SHALL hold the FSM state enum, GOLDEN_DEFAULT=16'hFC51, and the vector index width (4).
REQ-033 One sub-module ftran_rail_drv SHALL hold the registered dual-rail driver: 4-bit index in, 8 complementary rail outputs, async active-low reset to vector 0.

Verification
REQ-034 Behavioural gate model (correct f), default parameters, start pulse -> done at cycle 64 after start, pass=1, err_cnt=0, fail_map=16'h0000.
REQ-035 dut_out stuck at 0 -> err_cnt=9, fail_map=16'hFC51, first_fail=0, pass=0.
REQ-036 dut_out stuck at 1 -> err_cnt=7, fail_map=16'h03AE, first_fail=1, pass=0.
REQ-037 stop asserted in SETTLE of vector 5 -> busy=0 next cycle, no done pulse, rails = A..D=0 / not=1, err_cnt unchanged.
REQ-038 rst_n pulsed low in SAMPLE of vector 9, followed by a fresh start -> all outputs at reset values, then a full correct sweep with pass=1.
REQ-039 SETTLE_CYC=1 with start re-pulsed while busy -> sweep length 48 cycles, re-pulse ignored, and rail complementarity checked every cycle.

Source files
------------

// File: rtl/ftran_pkg.sv
// rtl/ftran_pkg.sv - shared types and constants for the gate sweep controller
package ftran_pkg;

  localparam logic [15:0] GOLDEN_DEFAULT = 16'hFC51;
  localparam int          IDX_W          = 4;
  localparam int          CNT_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  // Down-counter preload so that SETTLE spans exactly settle_cyc cycles
  function automatic logic [CNT_W-1:0] settle_load(input int settle_cyc);
    return CNT_W'(settle_cyc - 1);
  endfunction

endpackage

// File: rtl/ftran_rail_drv.sv
// rtl/ftran_rail_drv.sv - registered dual-rail vector driver, resets to vector 0
module ftran_rail_drv
  import ftran_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [IDX_W-1:0] vec,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             notA,
  output logic             notB,
  output logic             notC,
  output logic             notD
);

  // Both rails are separate flops loaded on the same edge so neither ever glitches
  logic [IDX_W-1:0] true_q, true_d;
  logic [IDX_W-1:0] comp_q, comp_d;

  // Next rail values: take the new vector on load, otherwise hold
  always_comb begin
    true_d = true_q;
    comp_d = comp_q;
    if (load) begin
      true_d = vec;
      comp_d = ~vec;
    end
  end

  // Rail registers; reset places vector 0 on the true rail and all ones on the complement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      true_q <= '0;
      comp_q <= '1;
    end else begin
      true_q <= true_d;
      comp_q <= comp_d;
    end
  end

  assign A    = true_q[3];
  assign B    = true_q[2];
  assign C    = true_q[1];
  assign D    = true_q[0];
  assign notA = comp_q[3];
  assign notB = comp_q[2];
  assign notC = comp_q[1];
  assign notD = comp_q[0];

endmodule

// File: rtl/ftran_sweep_ctrl.sv
// rtl/ftran_sweep_ctrl.sv - sweeps all 16 input vectors of a gate and logs mismatches
module ftran_sweep_ctrl
  import ftran_pkg::*;
#(
  parameter logic [15:0] GOLDEN     = GOLDEN_DEFAULT,
  parameter int          SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        dut_out,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        notA,
  output logic        notB,
  output logic        notC,
  output logic        notD,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_fail,
  output logic [15:0] fail_map
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [4:0]       err_q, err_d;
  logic [3:0]       ff_q, ff_d;
  logic [15:0]      map_q, map_d;
  logic             rail_load;
  logic [IDX_W-1:0] rail_vec;
  logic             mismatch;

  assign mismatch = (dut_out != GOLDEN[idx_q]);

  // Next-state and result bookkeeping; stop overrides everything while busy
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ff_d      = ff_q;
    map_d     = map_q;
    rail_load = 1'b0;
    rail_vec  = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          err_d   = '0;
          map_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        rail_load = 1'b1;
        rail_vec  = idx_q;
        cnt_d     = settle_load(SETTLE_CYC);
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          map_d[idx_q] = 1'b1;
          err_d        = err_q + 5'd1;
          if (err_q == '0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == 4'd15) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_FIN: begin
        rail_load = 1'b1;
        rail_vec  = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q == ST_SAMPLE && state_d == ST_FIN) begin
      pass_d = (err_d == '0);
    end

    if (state_q != ST_IDLE && stop) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      pass_d    = 1'b0;
      err_d     = err_q;
      map_d     = map_q;
      ff_d      = ff_q;
      rail_load = 1'b1;
      rail_vec  = '0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // FSM and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      map_q   <= map_d;
    end
  end

  ftran_rail_drv u_rail (
    .clk  (clk),
    .rst_n(rst_n),
    .load (rail_load),
    .vec  (rail_vec),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .notA (notA),
    .notB (notB),
    .notC (notC),
    .notD (notD)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
  assign fail_map   = map_q;

endmodule

// File: tb/tb_ftran_sweep_ctrl.sv
// tb/tb_ftran_sweep_ctrl.sv - scoreboard bench for the gate sweep controller
module tb_ftran_sweep_ctrl;

  localparam logic [15:0] GOLD = 16'hFC51;

  typedef struct {
    logic [4:0]  err;
    logic [15:0] map;
    logic [3:0]  ff;
    logic        pass;
    int          start_edge;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, stop0, dout0;
  logic        a0, b0, c0, d0, na0, nb0, nc0, nd0, busy0, done0, pass0;
  logic [4:0]  err0;
  logic [3:0]  ff0;
  logic [15:0] map0;
  logic        start1, stop1, dout1;
  logic        a1, b1, c1, d1, na1, nb1, nc1, nd1, busy1, done1, pass1;
  logic [4:0]  err1;
  logic [3:0]  ff1;
  logic [15:0] map1;

  int   mode0 = 0;
  int   mode1 = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  ftran_sweep_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .dut_out(dout0),
    .A(a0), .B(b0), .C(c0), .D(d0), .notA(na0), .notB(nb0), .notC(nc0), .notD(nd0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_fail(ff0), .fail_map(map0)
  );

  ftran_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .dut_out(dout1),
    .A(a1), .B(b1), .C(c1), .D(d1), .notA(na1), .notB(nb1), .notC(nc1), .notD(nd1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail(ff1), .fail_map(map1)
  );

  // Gate model: 0 = correct function, 1 = stuck at 0, 2 = stuck at 1
  function automatic logic model(input int mode, input logic [3:0] v);
    logic [15:0] g;
    g = GOLD;
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return g[v];
    endcase
  endfunction

  always_comb dout0 = model(mode0, {a0, b0, c0, d0});
  always_comb dout1 = model(mode1, {a1, b1, c1, d1});

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitors: rail complementarity every cycle, scoreboard pop on each done pulse
  always @(negedge clk) begin
    check("rails0_compl", {a0, b0, c0, d0}, ~{na0, nb0, nc0, nd0} & 4'hF);
    check("rails1_compl", {a1, b1, c1, d1}, ~{na1, nb1, nc1, nd1} & 4'hF);
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_done actual=1 expected=0");
      end else begin
        m0 = q0.pop_front();
        check("dut0_len", cyc - m0.start_edge, m0.len);
        check("dut0_err", err0, m0.err);
        check("dut0_map", map0, m0.map);
        check("dut0_ff", ff0, m0.ff);
        check("dut0_pass", pass0, m0.pass);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_done actual=1 expected=0");
      end else begin
        m1 = q1.pop_front();
        check("dut1_len", cyc - m1.start_edge, m1.len);
        check("dut1_err", err1, m1.err);
        check("dut1_map", map1, m1.map);
        check("dut1_ff", ff1, m1.ff);
        check("dut1_pass", pass1, m1.pass);
      end
    end
  end

  task automatic chk_reset0(input string tag);
    check({tag, "_rails"}, {a0, b0, c0, d0, na0, nb0, nc0, nd0}, 8'h0F);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_pass"}, pass0, 0);
    check({tag, "_err"}, err0, 0);
    check({tag, "_ff"}, ff0, 0);
    check({tag, "_map"}, map0, 0);
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    while (busy0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("dut0_idle_timeout", busy0, 0);
  endtask

  task automatic sweep0(input int mode, input logic [4:0] e_err, input logic [15:0] e_map,
                        input logic [3:0] e_ff, input logic e_pass);
    exp_t e;
    mode0        = mode;
    start0       = 1'b1;
    e.err        = e_err;
    e.map        = e_map;
    e.ff         = e_ff;
    e.pass       = e_pass;
    e.start_edge = cyc + 1;
    e.len        = 64;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    check("dut0_busy_after_start", busy0, 1);
    wait_idle0(200);
    repeat (3) @(negedge clk);
    check("dut0_hold_err", err0, e_err);
    check("dut0_hold_map", map0, e_map);
    check("dut0_hold_pass", pass0, e_pass);
  endtask

  initial begin
    int   e_edge;
    exp_t e;
    int   n;
    rst_n  = 1'b0;
    start0 = 1'b0;
    stop0  = 1'b0;
    start1 = 1'b0;
    stop1  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset0("rst0");
    check("rst1_rails", {a1, b1, c1, d1, na1, nb1, nc1, nd1}, 8'h0F);
    check("rst1_busy", busy1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep0(0, 5'd0, 16'h0000, 4'd0, 1'b1);
    sweep0(1, 5'd9, 16'hFC51, 4'd0, 1'b0);
    sweep0(2, 5'd7, 16'h03AE, 4'd1, 1'b0);

    // Abort during SETTLE of vector 5 with the gate stuck at 0
    mode0  = 1;
    start0 = 1'b1;
    e_edge = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < e_edge + 21) @(negedge clk);
    check("stop_rails_v5", {a0, b0, c0, d0}, 4'd5);
    check("stop_busy_before", busy0, 1);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;
    check("stop_busy", busy0, 0);
    check("stop_rails", {a0, b0, c0, d0, na0, nb0, nc0, nd0}, 8'h0F);
    check("stop_err", err0, 5'd2);
    check("stop_map", map0, 16'h0011);
    check("stop_ff", ff0, 0);
    check("stop_pass", pass0, 0);
    repeat (5) @(negedge clk);
    check("stop_hold_err", err0, 5'd2);

    // start together with stop in IDLE must not launch a sweep
    start0 = 1'b1;
    stop0  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    stop0  = 1'b0;
    check("startstop_busy", busy0, 0);
    @(negedge clk);
    check("startstop_busy2", busy0, 0);
    check("startstop_err_held", err0, 5'd2);

    // Reset pulse in SAMPLE of vector 9, then a fresh good sweep
    mode0  = 0;
    start0 = 1'b1;
    e_edge = cyc + 1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < e_edge + 39) @(negedge clk);
    check("rst_rails_v9", {a0, b0, c0, d0}, 4'd9);
    rst_n = 1'b0;
    #1;
    chk_reset0("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset0("postrst");
    sweep0(0, 5'd0, 16'h0000, 4'd0, 1'b1);

    // SETTLE_CYC=1 instance: 48-cycle sweep, re-pulse of start ignored
    mode1        = 0;
    start1       = 1'b1;
    e.err        = 5'd0;
    e.map        = 16'h0000;
    e.ff         = 4'd0;
    e.pass       = 1'b1;
    e.start_edge = cyc + 1;
    e.len        = 48;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    check("dut1_busy_mid", busy1, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dut1_idle_timeout", busy1, 0);
    repeat (60) @(negedge clk);
    check("dut1_no_restart", busy1, 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
